// File: rtl/row_normalizer_pkg.sv
// row_normalizer shared types: state encoding, operand widths and row typedefs.
// Fixed-point: numerators/denominator share one format; quotient has 7 frac bits.
package row_normalizer_pkg;

  localparam int DIV_INPUT_QT  = 16;
  localparam int OUTPUT_VEC_QT = 8;
  localparam int VEC_LEN_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } row_norm_state_t;

  typedef logic [VEC_LEN_DEF-1:0][DIV_INPUT_QT-1:0]  div_row_t;
  typedef logic [VEC_LEN_DEF-1:0][OUTPUT_VEC_QT-1:0] out_row_t;

endpackage

// File: rtl/row_normalizer.sv
// Row normalizer: streams one row through the shared divider, collects quotients.
// Option ROW_NORM_ZERO_BYPASS_EN: zero denominator skips the divider (saturates).
module row_normalizer
  import row_normalizer_pkg::*;
#(
  parameter int VEC_LEN         = VEC_LEN_DEF,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     vld_in,
  output logic                                     rdy_out,
  input  logic [VEC_LEN-1:0][DIV_INPUT_QT-1:0]     numerator_vec_in,
  input  logic [DIV_INPUT_QT-1:0]                  denominator_in,
  output logic                                     div_vld,
  input  logic                                     div_rdy,
  output logic [DIV_INPUT_QT-1:0]                  div_num,
  output logic [DIV_INPUT_QT-1:0]                  div_den,
  input  logic                                     div_quot_vld,
  output logic                                     div_quot_rdy,
  input  logic [OUTPUT_VEC_QT-1:0]                 div_quot,
  output logic                                     vld_out,
  input  logic                                     rdy_in,
  output logic [VEC_LEN-1:0][OUTPUT_VEC_QT-1:0]    row_out
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW = $clog2(VEC_LEN);

  row_norm_state_t state, state_nxt;

  logic [VEC_LEN-1:0][DIV_INPUT_QT-1:0]  row_q;
  logic [DIV_INPUT_QT-1:0]               den_q;
  logic [VEC_LEN-1:0][OUTPUT_VEC_QT-1:0] out_q;
  logic [CW-1:0]                         issue_idx;
  logic [CW-1:0]                         collect_idx;
  logic [OW-1:0]                         outstanding;

  logic issue_fire;
  logic collect_fire;
  logic accept;
  logic zero_byp;
  logic last_collect;

`ifdef ROW_NORM_ZERO_BYPASS_EN
  function automatic logic [OUTPUT_VEC_QT-1:0] sat(
    input logic [DIV_INPUT_QT-1:0] n
  );
    return n[DIV_INPUT_QT-1] ? {1'b1, {(OUTPUT_VEC_QT-1){1'b0}}}
                             : {1'b0, {(OUTPUT_VEC_QT-1){1'b1}}};
  endfunction

  assign zero_byp = (denominator_in == '0);
`else
  assign zero_byp = 1'b0;
`endif

  assign accept       = vld_in && rdy_out;
  assign issue_fire   = div_vld && div_rdy;
  assign collect_fire = div_quot_vld && div_quot_rdy;
  assign last_collect = collect_idx == CW'(VEC_LEN - 1);

  always_comb begin
    state_nxt    = state;
    rdy_out      = 1'b0;
    vld_out      = 1'b0;
    div_quot_rdy = 1'b0;
    div_vld      = 1'b0;
    unique case (state)
      IDLE: begin
        rdy_out = 1'b1;
        if (vld_in) state_nxt = zero_byp ? DONE : RUN;
      end
      RUN: begin
        div_quot_rdy = 1'b1;
        div_vld = (issue_idx < CW'(VEC_LEN)) &&
                  (outstanding < OW'(MAX_OUTSTANDING));
        if (collect_fire && last_collect) state_nxt = DONE;
      end
      DONE: begin
        vld_out = 1'b1;
        if (rdy_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands zeroed when not issuing; issue_idx < VEC_LEN whenever div_vld.
  assign div_num = div_vld ? row_q[issue_idx[IW-1:0]] : '0;
  assign div_den = div_vld ? den_q : '0;
  assign row_out = out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      row_q       <= '0;
      den_q       <= '0;
      out_q       <= '0;
      issue_idx   <= '0;
      collect_idx <= '0;
      outstanding <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        row_q       <= numerator_vec_in;
        den_q       <= denominator_in;
        issue_idx   <= '0;
        collect_idx <= '0;
        outstanding <= '0;
`ifdef ROW_NORM_ZERO_BYPASS_EN
        if (zero_byp) begin
          for (int i = 0; i < VEC_LEN; i++)
            out_q[i] <= sat(numerator_vec_in[i]);
        end
`endif
      end
      if (issue_fire) issue_idx <= issue_idx + CW'(1);
      if (collect_fire) begin
        out_q[collect_idx[IW-1:0]] <= div_quot;
        collect_idx <= collect_idx + CW'(1);
      end
      if (issue_fire && !collect_fire)
        outstanding <= outstanding + OW'(1);
      else if (!issue_fire && collect_fire)
        outstanding <= outstanding - OW'(1);
    end
  end

endmodule

// File: doc/row_normalizer.md
# row_normalizer

Final-normalization sequencer for the FlashAttention output path: takes one accumulated output row (VEC_LEN numerators) plus its softmax row-sum denominator, streams the element pairs through the shared `int_division` stage under vld/rdy handshake, collects the in-order quotients, and presents the completed normalized row (OUTPUT_VEC_QT elements) to the writeback stage. Sits between the online-softmax accumulator and output writeback; `int_division` is instantiated beside it by the parent.

## Interface
- VEC_LEN, 16, elements per row (≥2)
- MAX_OUTSTANDING, 4, max divides issued but not yet returned (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- vld_in  in  1  upstream row valid
- rdy_out  out  1  block can accept a row
- numerator_vec_in  in  VEC_LEN×DIV_INPUT_QT  accumulated row
- denominator_in  in  DIV_INPUT_QT  row sum ℓ
- div_vld  out  1  issue to divider (drives divider vld_in)
- div_rdy  in  1  divider ready (divider rdy_out)
- div_num, div_den  out  DIV_INPUT_QT each  operands
- div_quot_vld  in  1  divider result valid (divider vld_out)
- div_quot_rdy  out  1  result accept (divider rdy_in)
- div_quot  in  OUTPUT_VEC_QT  quotient
- vld_out  out  1  normalized row valid
- rdy_in  in  1  downstream ready
- row_out  out  VEC_LEN×OUTPUT_VEC_QT  normalized row

## Operation
- States: IDLE, RUN, DONE.
- IDLE: rdy_out=1. On vld_in&&rdy_out: latch full row and denominator, clear issue_idx, collect_idx, outstanding; → RUN.
- RUN: div_vld=1 while issue_idx<VEC_LEN and outstanding<MAX_OUTSTANDING; div_num=row[issue_idx], div_den=latched denominator. Issue fires on div_vld&&div_rdy: issue_idx++, outstanding++.
- RUN: div_quot_rdy=1 always. On div_quot_vld: row_out[collect_idx]←div_quot, collect_idx++, outstanding--.
- Same-cycle issue and collect: outstanding unchanged.
- Divider is in-order; no tags. div_quot_vld outside RUN is a protocol error: ignore, div_quot_rdy=0.
- collect_idx reaching VEC_LEN → DONE (issue necessarily complete).
- DONE: vld_out=1, row_out stable. On rdy_in → IDLE. No accept in the DONE→IDLE cycle; rdy_out rises the following cycle.
- Upstream row/denominator ignored except at acceptance; numerator_vec_in need not be held.
- Counters width $clog2(VEC_LEN+1); outstanding width $clog2(MAX_OUTSTANDING+1). No arithmetic on data; quotients stored bit-exact.

## Timing
- Reset (rst low, async): state IDLE, rdy_out=1, vld_out=0, div_vld=0, div_quot_rdy=0, div_num/div_den=0, row_out all 0, counters 0. Release synchronous to clk.
- Reset mid-row discards the partial row. The parent resets the divider on the same event, so no stale quotient survives.
- Accept at edge N; first div_vld asserted in cycle N+1.
- Row latency = 1 + divider-bound issue/collect time + 1 cycle into DONE. With a divider of fixed latency L accepting one op/cycle and MAX_OUTSTANDING≥L: VEC_LEN+L+1 cycles from accept to vld_out.
- vld_out held, row_out stable, until rdy_in; outputs registered.
- div_num/div_den stable while div_vld && !div_rdy.

## Configuration
- ROW_NORM_ZERO_BYPASS_EN defined: denominator_in==0 at acceptance skips the divider. RUN is bypassed and the block enters DONE the next cycle. Each row_out[i] is +max (127) if numerator≥0, else −max−1 (−128), matching divider saturation.
- Undefined: zero denominators go through the divider like any other value.

## Structure
- Add to `sys_defs.svh`: row_norm_state_t enum (IDLE/RUN/DONE), default VEC_LEN constant, DIV_ROW_T / OUT_ROW_T packed-array typedefs of DIV_INPUT_QT / OUTPUT_VEC_QT.
- Single module, no sub-module. The saturation helper for the bypass path is a local function.

## Test plan
Bench uses VEC_LEN=4, a divider model returning round(num·2^OUTPUT_VEC_F/den) after 3 cycles, and random backpressure on div_rdy.
- Row {0.5,0.25,0,0.75}, den 1.0 → row_out {64,32,0,96}, single vld_out pulse, order preserved.
- Same row, den 2.0, rdy_in low 5 cycles in DONE → vld_out held, row_out stable, then IDLE and rdy_out=1 one cycle after the handshake.
- MAX_OUTSTANDING=1 vs 4 with a fixed-latency divider → accept-to-vld_out equals VEC_LEN·(L+1)+1 vs VEC_LEN+L+1; outstanding never exceeds the limit.
- rst pulsed low after 2 quotients collected → immediate IDLE, vld_out=0, row_out=0; the next row is normalized correctly.
- den 0, row {0.5,−0.5,0,−1.0}, macro defined → {127,−128,127,−128} in DONE the cycle after accept, div_vld never asserted. Macro undefined → same values obtained via the divider.
- Back-to-back rows with vld_in held high → second row accepted only in IDLE; both rows correct.
